// File: rtl/lcd_pkg.sv
// lcd_pkg: shared state enum, HD44780 command codes and ROM word layout.
// Imported by the sequencer top and its delay timer.
package lcd_pkg;

  typedef enum logic [2:0] {
    POWERUP,
    FETCH,
    SETUP,
    PULSE,
    WAIT,
    IDLE
  } lcd_state_t;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  localparam int ROM_W        = 9;
  localparam int ROM_RS_BIT   = 8;
  localparam int ROM_DATA_MSB = 7;
  localparam int ROM_DATA_LSB = 0;

  // Clear (0x01) and home (0x02/0x03) need the long busy wait.
  function automatic logic is_slow_cmd(
    input logic       rs,
    input logic [7:0] data
  );
    return !rs && (data == LCD_CMD_CLEAR ||
                   data[7:1] == LCD_CMD_HOME[7:1]);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// lcd_delay_timer: loadable down-counter shared by all sequencer delays.
// Ports: clk, rst_n, load, value (W bits), done (count is zero).
module lcd_delay_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/lcd_init_sequencer.sv
// lcd_init_sequencer: HD44780 8-bit init from command ROM, then host writes.
// Ports: CLK, nRST, rom_addr/rom_q/rom_rdy (ROM side), wr_valid/wr_rs/
// wr_data/wr_ready (host), init_done, lcd_e/lcd_rs/lcd_rw/lcd_data (pins).
// Optional: LCD_REINIT_EN adds a reinit input honoured in IDLE.
module lcd_init_sequencer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 750000,
  parameter int SETUP_CYC      = 2,
  parameter int E_HIGH_CYC     = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 82000
) (
  input  logic             CLK,
  input  logic             nRST,
  output logic [2:0]       rom_addr,
  input  logic [ROM_W-1:0] rom_q,
  input  logic             rom_rdy,
  input  logic             wr_valid,
  input  logic             wr_rs,
  input  logic [7:0]       wr_data,
`ifdef LCD_REINIT_EN
  input  logic             reinit,
`endif
  output logic             wr_ready,
  output logic             init_done,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic [7:0]       lcd_data
);

  localparam int M0 = (POWERUP_CYC > CLEAR_WAIT_CYC) ?
                      POWERUP_CYC : CLEAR_WAIT_CYC;
  localparam int M1 = (CMD_WAIT_CYC > E_HIGH_CYC) ?
                      CMD_WAIT_CYC : E_HIGH_CYC;
  localparam int M2 = (M0 > M1) ? M0 : M1;
  localparam int MX = (M2 > SETUP_CYC) ? M2 : SETUP_CYC;
  localparam int W  = $clog2(MX) + 1;

  // Counter runs value..0 inclusive, so each state lasts value+1 cycles.
  // Power-up spends its first cycle loading, hence the extra -1.
  localparam logic [W-1:0] PU_LD  = W'(POWERUP_CYC - 2);
  localparam logic [W-1:0] SU_LD  = W'(SETUP_CYC - 1);
  localparam logic [W-1:0] EH_LD  = W'(E_HIGH_CYC - 1);
  localparam logic [W-1:0] CMD_LD = W'(CMD_WAIT_CYC - 1);
  localparam logic [W-1:0] CLR_LD = W'(CLEAR_WAIT_CYC - 1);

  lcd_state_t   state;
  logic         armed;
  logic         tmr_load;
  logic [W-1:0] tmr_value;
  logic         tmr_done;
  logic         reinit_hit;
  logic         host_take;

`ifdef LCD_REINIT_EN
  assign reinit_hit = (state == IDLE) && reinit;
`else
  assign reinit_hit = 1'b0;
`endif

  assign host_take = (state == IDLE) && wr_valid && !reinit_hit;
  assign lcd_rw = 1'b0;

  lcd_delay_timer #(
    .W(W)
  ) u_timer (
    .clk  (CLK),
    .rst_n(nRST),
    .load (tmr_load),
    .value(tmr_value),
    .done (tmr_done)
  );

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state)
      POWERUP: begin
        if (!armed) begin
          tmr_load  = 1'b1;
          tmr_value = PU_LD;
        end
      end
      FETCH: begin
        if (!rom_rdy) begin
          tmr_load  = 1'b1;
          tmr_value = SU_LD;
        end
      end
      SETUP: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = EH_LD;
        end
      end
      PULSE: begin
        if (tmr_done) begin
          tmr_load  = 1'b1;
          tmr_value = is_slow_cmd(lcd_rs, lcd_data) ?
                      CLR_LD : CMD_LD;
        end
      end
      IDLE: begin
        if (host_take) begin
          tmr_load  = 1'b1;
          tmr_value = SU_LD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= POWERUP;
      armed     <= 1'b0;
      rom_addr  <= '0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_data  <= '0;
      wr_ready  <= 1'b0;
      init_done <= 1'b0;
    end else begin
      unique case (state)
        POWERUP: begin
          armed <= 1'b1;
          if (armed && tmr_done) state <= FETCH;
        end
        FETCH: begin
          if (rom_rdy) begin
            init_done <= 1'b1;
            wr_ready  <= 1'b1;
            state     <= IDLE;
          end else begin
            lcd_rs   <= rom_q[ROM_RS_BIT];
            lcd_data <= rom_q[ROM_DATA_MSB:ROM_DATA_LSB];
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (tmr_done) begin
            lcd_e <= 1'b1;
            state <= PULSE;
          end
        end
        PULSE: begin
          if (tmr_done) begin
            lcd_e <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (tmr_done) begin
            if (init_done) begin
              wr_ready <= 1'b1;
              state    <= IDLE;
            end else if (rom_addr == 3'd7) begin
              // Last ROM slot: finish instead of wrapping to 0.
              init_done <= 1'b1;
              wr_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              rom_addr <= rom_addr + 3'd1;
              state    <= FETCH;
            end
          end
        end
        IDLE: begin
          if (reinit_hit) begin
            init_done <= 1'b0;
            wr_ready  <= 1'b0;
            rom_addr  <= '0;
            state     <= FETCH;
          end else if (host_take) begin
            lcd_rs   <= wr_rs;
            lcd_data <= wr_data;
            wr_ready <= 1'b0;
            state    <= SETUP;
          end
        end
        default: state <= POWERUP;
      endcase
    end
  end

endmodule
